modport_alu: RTL and testbench

//  Registered WIDTH-bit ALU: arithmetic (mode=1) or logical (mode=0) op chosen by cmd.

---
 rtl/alu_pkg.sv | 50 +++++
 rtl/modport_alu_core.sv | 120 ++++++++++++
 rtl/modport_alu.sv | 79 +++++++
 tb/tb_modport_alu.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the modport_alu slice.
//   DEF_WIDTH   : default operand width, taken from the `WIDTH macro (8 when not predefined)
//   arith_cmd_e : opcodes for mode=1 (arithmetic)
//   logic_cmd_e : opcodes for mode=0 (logical)
//   IV_*        : inp_valid encodings (bit0 = opa valid, bit1 = opb valid)
`ifndef WIDTH
`define WIDTH 8
`endif

package alu_pkg;

  localparam int unsigned DEF_WIDTH = `WIDTH;

  typedef enum logic [3:0] {
    A_ADD     = 4'd0,
    A_SUB     = 4'd1,
    A_ADD_CIN = 4'd2,
    A_SUB_CIN = 4'd3,
    A_INC_A   = 4'd4,
    A_DEC_A   = 4'd5,
    A_INC_B   = 4'd6,
    A_DEC_B   = 4'd7,
    A_CMP     = 4'd8,
    A_MUL_INC = 4'd9,
    A_MUL_SHL = 4'd10
  } arith_cmd_e;

  typedef enum logic [3:0] {
    L_AND     = 4'd0,
    L_NAND    = 4'd1,
    L_OR      = 4'd2,
    L_NOR     = 4'd3,
    L_XOR     = 4'd4,
    L_XNOR    = 4'd5,
    L_NOT_A   = 4'd6,
    L_NOT_B   = 4'd7,
    L_SHR1_A  = 4'd8,
    L_SHL1_A  = 4'd9,
    L_SHR1_B  = 4'd10,
    L_SHL1_B  = 4'd11,
    L_ROL_A_B = 4'd12,
    L_ROR_A_B = 4'd13
  } logic_cmd_e;

  localparam logic [1:0] IV_NONE = 2'b00;
  localparam logic [1:0] IV_A    = 2'b01;
  localparam logic [1:0] IV_B    = 2'b10;
  localparam logic [1:0] IV_AB   = 2'b11;

endpackage

// File: rtl/modport_alu_core.sv
// Combinational decode/compute for modport_alu: produces the next-state value of
// every registered output from the current inputs.
//   mode, cmd, inp_valid, opa, opb, cin : operation request
//   res_d, cout_d, oflow_d, g_d, l_d, e_d, err_d : next register values
// Macro MODPORT_ALU_MULT_EN enables arithmetic cmd 9/10 (multiplies); without it
// those opcodes decode as unused.
module modport_alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             mode,
  input  logic [3:0]       cmd,
  input  logic [1:0]       inp_valid,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             cin,
  output logic [WIDTH:0]   res_d,
  output logic             cout_d,
  output logic             oflow_d,
  output logic             g_d,
  output logic             l_d,
  output logic             e_d,
  output logic             err_d
);

  localparam int unsigned SH = $clog2(WIDTH);

  logic [WIDTH:0]   w_a;
  logic [WIDTH:0]   w_b;
  logic [WIDTH:0]   w_cin;
  logic [WIDTH:0]   w_one;
  logic [SH-1:0]    w_rot;
  logic             w_rot_hi;
  logic [WIDTH-1:0] w_rol;
  logic [WIDTH-1:0] w_ror;
  logic [WIDTH-1:0] w_lres;
  logic [1:0]       w_need;
  logic             w_known;

  assign w_a      = {1'b0, opa};
  assign w_b      = {1'b0, opb};
  assign w_cin    = {{WIDTH{1'b0}}, cin};
  assign w_one    = {{WIDTH{1'b0}}, 1'b1};
  assign w_rot    = opb[SH-1:0];
  // Rotate amount only uses the low opb bits; anything above is flagged as an error.
  assign w_rot_hi = |(opb >> SH);
  // A zero rotate shifts the wrap-around term out completely, leaving opa unchanged.
  assign w_rol    = (opa << w_rot) | (opa >> (WIDTH - w_rot));
  assign w_ror    = (opa >> w_rot) | (opa << (WIDTH - w_rot));

`ifdef MODPORT_ALU_MULT_EN
  localparam int unsigned PW = 2 * WIDTH + 2;
  logic [PW-1:0] w_prod_inc;
  logic [PW-1:0] w_prod_shl;
  assign w_prod_inc = PW'(w_a + w_one) * PW'(w_b + w_one);
  assign w_prod_shl = PW'(w_a << 1) * PW'(w_b);
`endif

  always_comb begin
    res_d   = '0;
    cout_d  = 1'b0;
    oflow_d = 1'b0;
    g_d     = 1'b0;
    l_d     = 1'b0;
    e_d     = 1'b0;
    err_d   = 1'b0;
    w_need  = IV_AB;
    w_known = 1'b1;
    w_lres  = '0;
    if (mode) begin
      case (arith_cmd_e'(cmd))
        A_ADD:     begin res_d = w_a + w_b; cout_d = res_d[WIDTH]; end
        A_SUB:     begin res_d = w_a - w_b; oflow_d = (w_a < w_b); end
        A_ADD_CIN: begin res_d = w_a + w_b + w_cin; cout_d = res_d[WIDTH]; end
        A_SUB_CIN: begin res_d = w_a - w_b - w_cin; oflow_d = (w_a < (w_b + w_cin)); end
        A_INC_A:   begin res_d = w_a + w_one; w_need = IV_A; end
        A_DEC_A:   begin res_d = w_a - w_one; w_need = IV_A; end
        A_INC_B:   begin res_d = w_b + w_one; w_need = IV_B; end
        A_DEC_B:   begin res_d = w_b - w_one; w_need = IV_B; end
        A_CMP:     begin g_d = (opa > opb); l_d = (opa < opb); e_d = (opa == opb); end
`ifdef MODPORT_ALU_MULT_EN
        A_MUL_INC: res_d = w_prod_inc[WIDTH:0];
        A_MUL_SHL: res_d = w_prod_shl[WIDTH:0];
`endif
        default:   w_known = 1'b0;
      endcase
    end else begin
      case (logic_cmd_e'(cmd))
        L_AND:     w_lres = opa & opb;
        L_NAND:    w_lres = ~(opa & opb);
        L_OR:      w_lres = opa | opb;
        L_NOR:     w_lres = ~(opa | opb);
        L_XOR:     w_lres = opa ^ opb;
        L_XNOR:    w_lres = ~(opa ^ opb);
        L_NOT_A:   begin w_lres = ~opa;      w_need = IV_A; end
        L_NOT_B:   begin w_lres = ~opb;      w_need = IV_B; end
        L_SHR1_A:  begin w_lres = opa >> 1;  w_need = IV_A; end
        L_SHL1_A:  begin w_lres = opa << 1;  w_need = IV_A; end
        L_SHR1_B:  begin w_lres = opb >> 1;  w_need = IV_B; end
        L_SHL1_B:  begin w_lres = opb << 1;  w_need = IV_B; end
        L_ROL_A_B: begin w_lres = w_rol; err_d = w_rot_hi; end
        L_ROR_A_B: begin w_lres = w_ror; err_d = w_rot_hi; end
        default:   w_known = 1'b0;
      endcase
      res_d = {1'b0, w_lres};
    end
    // Unused opcode or missing operand: discard whatever was computed above.
    if (!w_known || ((inp_valid & w_need) != w_need)) begin
      res_d   = '0;
      cout_d  = 1'b0;
      oflow_d = 1'b0;
      g_d     = 1'b0;
      l_d     = 1'b0;
      e_d     = 1'b0;
      err_d   = 1'b1;
    end
  end

endmodule

// File: rtl/modport_alu.sv
// Registered WIDTH-bit ALU, latency 1.
//   clk, rst (async, active-low), ce (0 = hold all registered outputs)
//   mode (1 arith / 0 logic), cmd[3:0], inp_valid[1:0], opa, opb, cin
//   res[WIDTH:0], cout, oflow, g, l, e : registered results/flags
//   err : registered error OR'd with "no operand valid" on the current inputs
// Macro MODPORT_ALU_MULT_EN enables arithmetic multiplies (cmd 9/10).
module modport_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             mode,
  input  logic [3:0]       cmd,
  input  logic [1:0]       inp_valid,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             cin,
  output logic [WIDTH:0]   res,
  output logic             cout,
  output logic             oflow,
  output logic             g,
  output logic             l,
  output logic             e,
  output logic             err
);

  logic [WIDTH:0] w_res;
  logic           w_cout, w_oflow, w_g, w_l, w_e, w_err;
  logic [WIDTH:0] r_res;
  logic           r_cout, r_oflow, r_g, r_l, r_e, r_err_q;

  modport_alu_core #(.WIDTH(WIDTH)) u_core (
    .mode      (mode),
    .cmd       (cmd),
    .inp_valid (inp_valid),
    .opa       (opa),
    .opb       (opb),
    .cin       (cin),
    .res_d     (w_res),
    .cout_d    (w_cout),
    .oflow_d   (w_oflow),
    .g_d       (w_g),
    .l_d       (w_l),
    .e_d       (w_e),
    .err_d     (w_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_res   <= '0;
      r_cout  <= 1'b0;
      r_oflow <= 1'b0;
      r_g     <= 1'b0;
      r_l     <= 1'b0;
      r_e     <= 1'b0;
      r_err_q <= 1'b0;
    end else if (ce) begin
      r_res   <= w_res;
      r_cout  <= w_cout;
      r_oflow <= w_oflow;
      r_g     <= w_g;
      r_l     <= w_l;
      r_e     <= w_e;
      r_err_q <= w_err;
    end
  end

  assign res   = r_res;
  assign cout  = r_cout;
  assign oflow = r_oflow;
  assign g     = r_g;
  assign l     = r_l;
  assign e     = r_e;
  assign err   = r_err_q | (inp_valid == IV_NONE);

endmodule

// File: tb/tb_modport_alu.sv
module tb_modport_alu;

  typedef struct {
    int unsigned res;
    bit cout, oflow, g, l, e, errq;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ce = 1'b1;
  logic       mode = 1'b0;
  logic [3:0] cmd = '0;
  logic [1:0] inp_valid = 2'b11;
  logic [7:0] opa = '0;
  logic [7:0] opb = '0;
  logic       cin = 1'b0;
  logic [8:0] res;
  logic       cout, oflow, g, l, e, err;

  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t        st;

  modport_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .ce(ce), .mode(mode), .cmd(cmd), .inp_valid(inp_valid),
    .opa(opa), .opb(opb), .cin(cin), .res(res), .cout(cout), .oflow(oflow),
    .g(g), .l(l), .e(e), .err(err)
  );

  always #5 clk = ~clk;

  function automatic exp_t zero_state();
    exp_t x;
    x.res = 0; x.cout = 0; x.oflow = 0; x.g = 0; x.l = 0; x.e = 0; x.errq = 0;
    return x;
  endfunction

  // Reference: plain integer arithmetic modulo 512 (9-bit result), 8-bit logic masked to 255.
  function automatic exp_t model(bit m, int unsigned c, int unsigned iv,
                                 int unsigned a, int unsigned b, int unsigned ci);
    exp_t x = zero_state();
    int unsigned need = 3;
    bit known = 1;
    int unsigned s, r;
    if (m) begin
      case (c)
        0: begin s = a + b; x.res = s % 512; x.cout = (s >= 256); end
        1: begin x.res = (a + 512 - b) % 512; x.oflow = (a < b); end
        2: begin s = a + b + ci; x.res = s % 512; x.cout = (s >= 256); end
        3: begin x.res = (a + 512 - b - ci) % 512; x.oflow = (a < b + ci); end
        4: begin x.res = (a + 1) % 512; need = 1; end
        5: begin x.res = (a + 511) % 512; need = 1; end
        6: begin x.res = (b + 1) % 512; need = 2; end
        7: begin x.res = (b + 511) % 512; need = 2; end
        8: begin x.g = (a > b); x.l = (a < b); x.e = (a == b); end
`ifdef MODPORT_ALU_MULT_EN
        9:  x.res = ((a + 1) * (b + 1)) % 512;
        10: x.res = (2 * a * b) % 512;
`endif
        default: known = 0;
      endcase
    end else begin
      case (c)
        0:  x.res = a & b;
        1:  x.res = 255 - (a & b);
        2:  x.res = a | b;
        3:  x.res = 255 - (a | b);
        4:  x.res = a ^ b;
        5:  x.res = 255 - (a ^ b);
        6:  begin x.res = 255 - a; need = 1; end
        7:  begin x.res = 255 - b; need = 2; end
        8:  begin x.res = a / 2; need = 1; end
        9:  begin x.res = (a * 2) % 256; need = 1; end
        10: begin x.res = b / 2; need = 2; end
        11: begin x.res = (b * 2) % 256; need = 2; end
        12, 13: begin
          r = a;
          for (int unsigned k = 0; k < b % 8; k++) begin
            if (c == 12) r = (r * 2) % 256 + r / 128;
            else         r = r / 2 + (r % 2) * 128;
          end
          x.res = r;
          x.errq = (b >= 8);
        end
        default: known = 0;
      endcase
    end
    if (!known || ((iv & need) != need)) begin
      x = zero_state();
      x.errq = 1;
    end
    return x;
  endfunction

  task automatic check(input string tag);
    logic [14:0] obs, exp;
    obs = {res, cout, oflow, g, l, e, err};
    exp = {st.res[8:0], st.cout, st.oflow, st.g, st.l, st.e,
           st.errq | (inp_valid == 2'b00)};
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed={res,cout,oflow,g,l,e,err}=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Drive one request between edges, capture it on the next posedge, check 1 ns later.
  task automatic step(input string tag, input bit m, input logic [3:0] c, input logic [1:0] iv,
                      input logic [7:0] a, input logic [7:0] b, input bit ci, input bit en);
    @(negedge clk);
    mode = m; cmd = c; inp_valid = iv; opa = a; opb = b; cin = ci; ce = en;
    @(posedge clk);
    if (rst && en) st = model(m, c, iv, a, b, ci);
    #1;
    check(tag);
  endtask

  initial begin
    st = zero_state();
    #12;
    check("reset_state");
    @(negedge clk);
    rst = 1'b1;

    step("add_ff_01", 1'b1, 4'd0, 2'b11, 8'hFF, 8'h01, 1'b0, 1'b1);
    // Asynchronous reset in the middle of a cycle
    #2 rst = 1'b0;
    st = zero_state();
    #1 check("async_reset");
    inp_valid = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    #1 check("release_iv00_err");
    step("iv00_edge", 1'b1, 4'd0, 2'b00, 8'h10, 8'h20, 1'b0, 1'b1);

    step("add_ff_01_b", 1'b1, 4'd0, 2'b11, 8'hFF, 8'h01, 1'b0, 1'b1);
    step("cmp_lt", 1'b1, 4'd8, 2'b11, 8'd5, 8'd9, 1'b0, 1'b1);
    step("cmp_eq", 1'b1, 4'd8, 2'b11, 8'd7, 8'd7, 1'b0, 1'b1);
    step("rol_81_01", 1'b0, 4'd12, 2'b11, 8'h81, 8'h01, 1'b0, 1'b1);
    step("rol_81_11", 1'b0, 4'd12, 2'b11, 8'h81, 8'h11, 1'b0, 1'b1);
    step("ror_81_03", 1'b0, 4'd13, 2'b11, 8'h81, 8'h03, 1'b0, 1'b1);
    step("and_iv01", 1'b0, 4'd0, 2'b01, 8'hF0, 8'h3C, 1'b0, 1'b1);
    step("ce0_hold", 1'b1, 4'd0, 2'b11, 8'h12, 8'h34, 1'b1, 1'b0);
    step("mul_inc_2_3", 1'b1, 4'd9, 2'b11, 8'd2, 8'd3, 1'b0, 1'b1);
    step("mul_shl_3_5", 1'b1, 4'd10, 2'b11, 8'd3, 8'd5, 1'b0, 1'b1);
    step("arith_unused", 1'b1, 4'd12, 2'b11, 8'd1, 8'd1, 1'b0, 1'b1);
    step("logic_unused", 1'b0, 4'd15, 2'b11, 8'd1, 8'd1, 1'b0, 1'b1);
    step("dec_a_zero", 1'b1, 4'd5, 2'b01, 8'd0, 8'd0, 1'b0, 1'b1);
    step("sub_cin_borrow", 1'b1, 4'd3, 2'b11, 8'd4, 8'd4, 1'b1, 1'b1);
    step("inc_b_need_b", 1'b1, 4'd6, 2'b01, 8'd9, 8'd9, 1'b0, 1'b1);
    step("not_b_ok", 1'b0, 4'd7, 2'b10, 8'h00, 8'h5A, 1'b0, 1'b1);

    for (int i = 0; i < 300; i++) begin
      logic [1:0] iv;
      iv = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      step("random", 1'($urandom), 4'($urandom), iv, 8'($urandom), 8'($urandom),
           1'($urandom), ($urandom_range(0, 7) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
